// File: rtl/anton_neopixel_pixel_shifter_pkg.sv
// Shared definitions for the NeoPixel pixel shifter: buffer defaults, GRB
// word layout, high-time defaults and the shadow-register FSM encoding.
package anton_neopixel_pixel_shifter_pkg;

  localparam int unsigned BUFFER_END_DEFAULT = 63;
  localparam int unsigned T0H_TICKS_DEFAULT  = 2;
  localparam int unsigned T1H_TICKS_DEFAULT  = 5;
  localparam int unsigned PIXEL_MSB          = 23;

  typedef enum logic [1:0] {
    SHADOW_EMPTY,
    SHADOW_REQ,
    SHADOW_FULL
  } shadowState_t;

  // GRB words go out MSB first; indexes past the last bit read as zero.
  function automatic logic pixelBit(input logic [PIXEL_MSB:0] word,
                                    input logic [4:0] bitIndex);
    logic [4:0] pos;
    pos = 5'(PIXEL_MSB) - bitIndex;
    return (bitIndex <= 5'(PIXEL_MSB)) ? word[pos] : 1'b0;
  endfunction

endpackage

// File: rtl/anton_neopixel_bit_encoder.sv
// Turns one data bit plus its sub-bit slot into the registered NeoPixel level.
module anton_neopixel_bit_encoder #(
  parameter int unsigned T0H_TICKS = 2,
  parameter int unsigned T1H_TICKS = 5
) (
  input  logic       clk6_4mhz,
  input  logic       rstn,
  input  logic       enable,
  input  logic       bitValue,
  input  logic [2:0] bitPatternIndex,
  output logic       neoData
);

  logic [3:0] highTicks;
  logic       level;

  always_comb begin
    highTicks = bitValue ? 4'(T1H_TICKS) : 4'(T0H_TICKS);
    level     = enable && ({1'b0, bitPatternIndex} < highTicks);
  end

  always_ff @(posedge clk6_4mhz or negedge rstn) begin
    if (!rstn) neoData <= 1'b0;
    else       neoData <= level;
  end

endmodule

// File: rtl/anton_neopixel_pixel_shifter.sv
// Prefetches GRB pixel words one pixel ahead and serialises them onto neoData.
// Optional: ANTON_NEOPIXEL_UNDERRUN_CNT_EN adds the saturating underrunCount output.
module anton_neopixel_pixel_shifter
  import anton_neopixel_pixel_shifter_pkg::*;
#(
  parameter int unsigned BUFFER_END  = BUFFER_END_DEFAULT,
  parameter int unsigned BUFFER_BITS = $clog2(BUFFER_END + 1),
  parameter int unsigned T0H_TICKS   = T0H_TICKS_DEFAULT,
  parameter int unsigned T1H_TICKS   = T1H_TICKS_DEFAULT
) (
  input  logic                   clk6_4mhz,
  input  logic                   rstn,
  input  logic                   streamOutput,
  input  logic                   streamReset,
  input  logic [2:0]             bitPatternIndex,
  input  logic [4:0]             pixelBitIndex,
  input  logic [BUFFER_BITS-1:0] pixelIndex,
  input  logic [BUFFER_BITS-1:0] pixelIndexMax,
  input  logic                   regCtrl32bit,
  input  logic                   initSlow,
  output logic                   fetchReq,
  output logic [BUFFER_BITS-1:0] fetchAddr,
  input  logic                   fetchAck,
  input  logic [23:0]            fetchData,
  input  logic                   underrunClr,
  output logic                   underrun,
`ifdef ANTON_NEOPIXEL_UNDERRUN_CNT_EN
  output logic [7:0]             underrunCount,
`endif
  output logic                   neoData
);

  shadowState_t           state, stateN;
  logic [23:0]            shadow, shadowN, shiftReg, shiftN;
  logic [BUFFER_BITS-1:0] nextAddr, nextAddrN, fetchAddrN, followAddr, maxCmp, strideVal;
  logic                   fetchReqN, discard, discardN, pending, pendingN;
  logic                   streamResetQ, resetRise, pixelStart, trigger, underrunSet;
  logic                   curBit, encEnable;

  always_comb begin
    pixelStart = streamOutput && (pixelBitIndex == 5'd0) && (bitPatternIndex == 3'd0);
    resetRise  = streamReset && !streamResetQ;
    strideVal  = regCtrl32bit ? BUFFER_BITS'(4) : BUFFER_BITS'(1);
    maxCmp     = regCtrl32bit ? {pixelIndex[BUFFER_BITS-1:2], 2'b11} : pixelIndex;
    followAddr = (maxCmp == pixelIndexMax) ? '0 : pixelIndex + strideVal;
  end

  always_comb begin
    stateN      = state;
    shadowN     = shadow;
    shiftN      = shiftReg;
    nextAddrN   = nextAddr;
    fetchReqN   = fetchReq;
    fetchAddrN  = fetchAddr;
    discardN    = discard;
    pendingN    = pending;
    trigger     = 1'b0;
    underrunSet = 1'b0;

    if (fetchReq && fetchAck) begin
      fetchReqN = 1'b0;
      discardN  = 1'b0;
      if (!discard && state == SHADOW_REQ) begin
        shadowN = fetchData;
        stateN  = SHADOW_FULL;
      end
    end

    if (pixelStart) begin
      nextAddrN = followAddr;
      trigger   = 1'b1;
      stateN    = SHADOW_EMPTY;
      if (state == SHADOW_FULL) begin
        shiftN = shadow;
      end else begin
        shiftN      = '0;
        underrunSet = 1'b1;
        if (fetchReq && !fetchAck) discardN = 1'b1;
      end
    end else if (resetRise && state == SHADOW_EMPTY) begin
      nextAddrN = '0;
      trigger   = 1'b1;
    end

    // A request still in flight must finish (and drop fetchReq) before the next one.
    if (trigger || pending) begin
      if (!fetchReq) begin
        fetchReqN  = 1'b1;
        fetchAddrN = nextAddrN;
        stateN     = SHADOW_REQ;
        pendingN   = 1'b0;
      end else begin
        pendingN = 1'b1;
      end
    end

    if (initSlow) begin
      stateN    = SHADOW_EMPTY;
      nextAddrN = '0;
      shiftN    = '0;
      pendingN  = 1'b0;
      if (fetchReq && !fetchAck) discardN = 1'b1;
    end
  end

  always_ff @(posedge clk6_4mhz or negedge rstn) begin
    if (!rstn) begin
      state        <= SHADOW_EMPTY;
      shadow       <= '0;
      shiftReg     <= '0;
      nextAddr     <= '0;
      fetchReq     <= 1'b0;
      fetchAddr    <= '0;
      discard      <= 1'b0;
      pending      <= 1'b0;
      streamResetQ <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      state        <= stateN;
      shadow       <= shadowN;
      shiftReg     <= shiftN;
      nextAddr     <= nextAddrN;
      fetchReq     <= fetchReqN;
      fetchAddr    <= fetchAddrN;
      discard      <= discardN;
      pending      <= pendingN;
      streamResetQ <= streamReset;
      underrun     <= underrunSet ? 1'b1 : (underrunClr ? 1'b0 : underrun);
    end
  end

`ifdef ANTON_NEOPIXEL_UNDERRUN_CNT_EN
  always_ff @(posedge clk6_4mhz or negedge rstn) begin
    if (!rstn)                underrunCount <= '0;
    else if (underrunSet)     underrunCount <= (underrunCount == '1) ? underrunCount : underrunCount + 8'd1;
    else if (underrunClr)     underrunCount <= '0;
  end
`endif

  // On the start cycle the word has not reached shiftReg yet, so read the shadow.
  always_comb begin
    if (pixelStart) curBit = (state == SHADOW_FULL) ? pixelBit(shadow, pixelBitIndex) : 1'b0;
    else            curBit = pixelBit(shiftReg, pixelBitIndex);
    encEnable = streamOutput && !streamReset && !initSlow;
  end

  anton_neopixel_bit_encoder #(
    .T0H_TICKS(T0H_TICKS),
    .T1H_TICKS(T1H_TICKS)
  ) bitEncoder (
    .clk6_4mhz      (clk6_4mhz),
    .rstn           (rstn),
    .enable         (encEnable),
    .bitValue       (curBit),
    .bitPatternIndex(bitPatternIndex),
    .neoData        (neoData)
  );

endmodule

// File: tb/tb_anton_neopixel_pixel_shifter.sv
// Directed bench: drives the stream indexes, answers fetches from a small memory
// and compares neoData/underrun against a pixel-plan waveform model every cycle.
`timescale 1ns/1ps
module tb_anton_neopixel_pixel_shifter;

  localparam int unsigned BB = 6;

  logic          clk6_4mhz = 1'b0;
  logic          rstn, streamOutput, streamReset, regCtrl32bit, initSlow, underrunClr;
  logic [2:0]    bitPatternIndex;
  logic [4:0]    pixelBitIndex;
  logic [BB-1:0] pixelIndex, pixelIndexMax, fetchAddr;
  logic          fetchReq, underrun, neoData;
  logic          fetchAck = 1'b0;
  logic [23:0]   fetchData = '0;
`ifdef ANTON_NEOPIXEL_UNDERRUN_CNT_EN
  logic [7:0]    underrunCount;
`endif

  int tests = 0;
  int fails = 0;

  always #78 clk6_4mhz = ~clk6_4mhz;

  anton_neopixel_pixel_shifter #(.BUFFER_END(63)) dut (
    .clk6_4mhz      (clk6_4mhz),
    .rstn           (rstn),
    .streamOutput   (streamOutput),
    .streamReset    (streamReset),
    .bitPatternIndex(bitPatternIndex),
    .pixelBitIndex  (pixelBitIndex),
    .pixelIndex     (pixelIndex),
    .pixelIndexMax  (pixelIndexMax),
    .regCtrl32bit   (regCtrl32bit),
    .initSlow       (initSlow),
    .fetchReq       (fetchReq),
    .fetchAddr      (fetchAddr),
    .fetchAck       (fetchAck),
    .fetchData      (fetchData),
    .underrunClr    (underrunClr),
    .underrun       (underrun),
`ifdef ANTON_NEOPIXEL_UNDERRUN_CNT_EN
    .underrunCount  (underrunCount),
`endif
    .neoData        (neoData)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Pixel plan: {underrun, word} per pixel start; expected fetch address order.
  logic [23:0]   mem [0:63];
  logic [24:0]   expPixQ[$];
  logic [BB-1:0] expAddrQ[$];

  // Waveform/flag model, one cycle behind the inputs it is computed from.
  bit          modelOn  = 0;
  logic        expNeo   = 1'b0;
  logic        expUnder = 1'b0;
  logic [7:0]  expCount = '0;
  logic [23:0] curPix   = '0;

  always @(negedge clk6_4mhz) begin
    logic isStart, setU, b;
    logic [24:0] e;
    if (modelOn) begin
      check("neoData", neoData, rstn ? expNeo : 1'b0);
      check("underrun", underrun, rstn ? expUnder : 1'b0);
`ifdef ANTON_NEOPIXEL_UNDERRUN_CNT_EN
      check("underrunCount", underrunCount, rstn ? expCount : 8'd0);
`endif
    end
    setU = 1'b0;
    if (!rstn) begin
      expNeo = 1'b0; expUnder = 1'b0; expCount = '0; curPix = '0;
    end else begin
      isStart = streamOutput && pixelBitIndex == 0 && bitPatternIndex == 0;
      if (isStart && modelOn) begin
        if (expPixQ.size() == 0) begin
          tests++; fails++;
          $display("FAIL pixelPlan: unplanned pixel start at index %0d", pixelIndex);
        end else begin
          e = expPixQ.pop_front();
          curPix = e[23:0];
          setU = e[24];
        end
      end
      if (initSlow) curPix = '0;
      b = (pixelBitIndex <= 23) ? curPix[23 - pixelBitIndex] : 1'b0;
      expNeo = streamOutput && !streamReset && !initSlow && (bitPatternIndex < (b ? 5 : 2));
      if (setU) expUnder = 1'b1;
      else if (underrunClr) expUnder = 1'b0;
      if (setU) expCount = (expCount == 8'hFF) ? expCount : expCount + 8'd1;
      else if (underrunClr) expCount = '0;
    end
  end

  // Pixel-buffer responder: checks each request address, acks after ackDelay cycles.
  int            reqAge   = 0;
  int            ackDelay = 2;
  bit            ackSent  = 0;
  bit            holdAck  = 0;
  logic [BB-1:0] reqAddr  = '0;

  always @(negedge clk6_4mhz) begin
    fetchAck = 1'b0;
    if (!rstn || !fetchReq) begin
      reqAge = 0; ackSent = 0;
    end else if (!ackSent) begin
      if (reqAge == 0) begin
        reqAddr = fetchAddr;
        if (expAddrQ.size() == 0) begin
          tests++; fails++;
          $display("FAIL fetchAddr: unplanned request for %0d", fetchAddr);
        end else begin
          check("fetchAddr", fetchAddr, expAddrQ.pop_front());
        end
      end else begin
        check("fetchAddrStable", fetchAddr, reqAddr);
      end
      reqAge++;
      if (reqAge > ackDelay && !holdAck) begin
        fetchAck = 1'b1; fetchData = mem[fetchAddr]; ackSent = 1;
      end
    end
  end

  logic cap [0:191];
  int   ones;
  logic capReq0;
  logic [BB-1:0] capAddr0;
  logic [7:0] first8;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk6_4mhz);
      #1;
    end
  endtask

  task automatic resetPhase(input int n);
    streamOutput = 1'b0; streamReset = 1'b1; pixelBitIndex = '0; bitPatternIndex = '0;
    cyc(n);
    streamReset = 1'b0;
  endtask

  task automatic sendPixel(input int idx, input int stopAt);
    streamOutput = 1'b1; pixelIndex = BB'(idx); ones = 0;
    for (int k = 0; k < stopAt; k++) begin
      pixelBitIndex = 5'(k / 8); bitPatternIndex = 3'(k % 8);
      cyc(1);
      cap[k] = neoData;
      if (neoData) ones++;
      if (k == 0) begin capReq0 = fetchReq; capAddr0 = fetchAddr; end
    end
    if (stopAt == 192) begin
      streamOutput = 1'b0; pixelBitIndex = '0; bitPatternIndex = '0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; streamOutput = 1'b0; streamReset = 1'b0; bitPatternIndex = '0;
    pixelBitIndex = '0; pixelIndex = '0; pixelIndexMax = '0; regCtrl32bit = 1'b0;
    initSlow = 1'b0; underrunClr = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 24'h100000 + 24'(i);
    mem[0] = 24'hFF0000; mem[1] = 24'h000000; mem[4] = 24'hA5C30F;
    cyc(3);
    check("rstFetchReq", fetchReq, 1'b0);
    check("rstFetchAddr", fetchAddr, '0);
    check("rstNeoData", neoData, 1'b0);
    check("rstUnderrun", underrun, 1'b0);
    rstn = 1'b1; modelOn = 1;

    // Frame A: prefetch of 0, then a '1'-heavy pixel and an all-zero pixel.
    pixelIndexMax = 1;
    expAddrQ.push_back(0);
    resetPhase(10);
    expPixQ.push_back({1'b0, mem[0]}); expAddrQ.push_back(1);
    sendPixel(0, 192);
    for (int i = 0; i < 8; i++) first8[7-i] = cap[i];
    check("firstBitShape", first8, 8'b11111000);
    check("pixFF0000High", ones, 72);
    check("reqAfterStart", capReq0, 1'b1);
    check("addrAfterStart", capAddr0, 1);
    expPixQ.push_back({1'b0, mem[1]}); expAddrQ.push_back(0);
    sendPixel(1, 192);
    check("pixZeroHigh", ones, 48);
    check("addrWrapAtMax", capAddr0, 0);
    cyc(5);

    // Frame B: flush, then 32-bit stride with max 7.
    initSlow = 1'b1; cyc(1); initSlow = 1'b0; cyc(2);
    regCtrl32bit = 1'b1; pixelIndexMax = 7;
    expAddrQ.push_back(0);
    resetPhase(10);
    expPixQ.push_back({1'b0, mem[0]}); expAddrQ.push_back(4);
    sendPixel(0, 192);
    check("addrStride4", capAddr0, 4);
    expPixQ.push_back({1'b0, mem[4]}); expAddrQ.push_back(0);
    sendPixel(4, 192);
    check("addrWrap32", capAddr0, 0);
    cyc(5);
    regCtrl32bit = 1'b0;

    // Frame C: late ack -> dark pixel; clear coincides with the underrun.
    pixelIndexMax = 1;
    resetPhase(10);
    holdAck = 1;
    expPixQ.push_back({1'b0, mem[0]}); expAddrQ.push_back(1);
    sendPixel(0, 192);
    check("noUnderrunYet", underrun, 1'b0);
    expPixQ.push_back({1'b1, 24'h000000}); expAddrQ.push_back(0);
    fork
      sendPixel(1, 192);
      begin underrunClr = 1'b1; cyc(1); underrunClr = 1'b0; cyc(20); holdAck = 0; end
    join
    check("clrRaceKeepsFlag", underrun, 1'b1);
    check("darkPixelHigh", ones, 48);
`ifdef ANTON_NEOPIXEL_UNDERRUN_CNT_EN
    check("countAfterUnderrun", underrunCount, 8'd1);
`endif
    cyc(5);

    // Frame D: the late word was discarded, so pixel 0 is word 0 again; reset mid-request.
    pixelIndexMax = 0;
    resetPhase(10);
    holdAck = 1;
    expPixQ.push_back({1'b0, mem[0]}); expAddrQ.push_back(0);
    sendPixel(0, 3);
    check("preRstReq", fetchReq, 1'b1);
    check("preRstNeo", neoData, 1'b1);
    check("preRstUnderrun", underrun, 1'b1);
    #20 rstn = 1'b0;
    #1;
    check("asyncRstReq", fetchReq, 1'b0);
    check("asyncRstNeo", neoData, 1'b0);
    check("asyncRstUnderrun", underrun, 1'b0);
    streamOutput = 1'b0; pixelBitIndex = '0; bitPatternIndex = '0; holdAck = 0;
    repeat (2) @(negedge clk6_4mhz);
    #20 rstn = 1'b1;
    @(posedge clk6_4mhz);
    #1;

    // Frame E: resume from the streamReset prefetch; underrun then a plain clear.
    pixelIndexMax = 1;
    expAddrQ.push_back(0);
    resetPhase(10);
    holdAck = 1;
    expPixQ.push_back({1'b0, mem[0]}); expAddrQ.push_back(1);
    sendPixel(0, 192);
    check("resumePixHigh", ones, 72);
    expPixQ.push_back({1'b1, 24'h000000}); expAddrQ.push_back(0);
    fork
      sendPixel(1, 192);
      begin cyc(30); underrunClr = 1'b1; cyc(1); underrunClr = 1'b0; cyc(10); holdAck = 0; end
    join
    check("plainClear", underrun, 1'b0);
    cyc(20);
    check("addrPlanDone", expAddrQ.size(), 0);
    check("pixPlanDone", expPixQ.size(), 0);
    check("idleReq", fetchReq, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
